// File: rtl/serial_addsub16.sv
// rtl/serial_addsub16.sv - nibble-serial adder/subtractor driving an external 4-bit ripple-carry adder
module serial_addsub16 #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   sub,
    output logic [3:0]             rca_a,
    output logic [3:0]             rca_b,
    output logic                   rca_cin,
    input  logic [3:0]             rca_s,
    input  logic                   rca_cout,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf,
    output logic                   zero,
    output logic                   done
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  result_q;
    logic          carry_q;
    logic          cout_q;
    logic          ovf_q;
    logic          zero_q;
    logic          done_q;

    logic          running;
    logic [IW+1:0] shamt;
    logic [W-1:0]  result_d;

    // Bit offset of the active nibble; result_d merges the adder's sum into it.
    always_comb begin
        running  = (state_q == RUN);
        shamt    = {idx_q, 2'b00};
        result_d = result_q;
        result_d[shamt +: 4] = rca_s;
    end

    assign start_ready = (state_q == IDLE);
    assign rca_a       = running ? a_q[shamt +: 4] : 4'h0;
    assign rca_b       = running ? b_q[shamt +: 4] : 4'h0;
    assign rca_cin     = running & carry_q;
    assign result      = result_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
    assign done        = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q      <= op_a;
                        b_q      <= sub ? ~op_b : op_b;
                        carry_q  <= sub;
                        idx_q    <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= rca_cout;
                    idx_q    <= idx_q + 1'b1;
                    // Flags are taken from the fully assembled result on the final nibble.
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        cout_q  <= rca_cout;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
                        zero_q  <= (result_d == '0);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub16.sv
// tb/tb_serial_addsub16.sv - randomized self-checking bench for serial_addsub16
module tb_serial_addsub16;
    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic [3:0]   rca_a;
    logic [3:0]   rca_b;
    logic         rca_cin;
    logic [3:0]   rca_s;
    logic         rca_cout;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign {rca_cout, rca_s} = 5'(rca_a) + 5'(rca_b) + 5'(rca_cin);

    serial_addsub16 #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .sub        (sub),
        .rca_a      (rca_a),
        .rca_b      (rca_b),
        .rca_cin    (rca_cin),
        .rca_s      (rca_s),
        .rca_cout   (rca_cout),
        .result     (result),
        .cout       (cout),
        .ovf        (ovf),
        .zero       (zero),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow by range check.
    function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint       full;
        int           sa;
        int           sb;
        int           sfull;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        sa = $signed(a);
        sb = $signed(b);
        if (s) begin
            full  = longint'(a) - longint'(b);
            c     = (a >= b);
            sfull = sa - sb;
        end else begin
            full  = longint'(a) + longint'(b);
            c     = (full >= 65536);
            sfull = sa + sb;
        end
        r = full[W-1:0];
        o = (sfull > 32767) || (sfull < -32768);
        return {c, o, (r == '0), r};
    endfunction

    int           phase = 0;
    logic [W-1:0] p_a   = '0;
    logic [W-1:0] p_b   = '0;
    logic         p_sub = 1'b0;
    logic [W-1:0] e_res = '0;
    logic         e_c   = 1'b0;
    logic         e_o   = 1'b0;
    logic         e_z   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 0;
            e_res <= '0;
            e_c   <= 1'b0;
            e_o   <= 1'b0;
            e_z   <= 1'b0;
        end else if (phase == 0) begin
            if (start_valid) begin
                phase <= 1;
                p_a   <= op_a;
                p_b   <= op_b;
                p_sub <= sub;
            end
        end else if (phase < NIB) begin
            phase <= phase + 1;
        end else if (phase == NIB) begin
            phase <= NIB + 1;
            {e_c, e_o, e_z, e_res} <= ref_op(p_a, p_b, p_sub);
        end else begin
            phase <= 0;
        end
    end

    int           k;
    logic [W-1:0] beff;
    longint       mk;
    longint       ssum;

    always @(negedge clk) begin
        if (!rst) check("start_ready", 32'(start_ready), 32'(phase == 0));
        check("done", 32'(done), 32'(phase == NIB + 1));
        if (phase >= 1 && phase <= NIB) begin
            k    = phase - 1;
            beff = p_sub ? ~p_b : p_b;
            mk   = (longint'(1) << (4 * k)) - 1;
            ssum = (longint'(p_a) & mk) + (longint'(beff) & mk) + longint'(p_sub);
            check("rca_a", 32'(rca_a), 32'((p_a >> (4 * k)) & 16'h000F));
            check("rca_b", 32'(rca_b), 32'((beff >> (4 * k)) & 16'h000F));
            check("rca_cin", 32'(rca_cin), 32'((ssum >> (4 * k)) & 1));
        end else begin
            check("rca_a_idle", 32'(rca_a), 32'd0);
            check("rca_b_idle", 32'(rca_b), 32'd0);
            check("rca_cin_idle", 32'(rca_cin), 32'd0);
            check("result", 32'(result), 32'(e_res));
            check("cout", 32'(cout), 32'(e_c));
            check("ovf", 32'(ovf), 32'(e_o));
            check("zero", 32'(zero), 32'(e_z));
        end
    end

    // Starts #1 after a rising edge with the block idle; returns #1 after the edge leaving DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit lit,
                          input logic [W-1:0] xr, input logic xc, input logic xo, input logic xz);
        int t;
        op_a        = a;
        op_b        = b;
        sub         = s;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a        = 16'($urandom);
        op_b        = 16'($urandom);
        sub         = 1'($urandom);
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("latency", 32'(t), 32'd5);
        if (lit) begin
            check("lit_result", 32'(result), 32'(xr));
            check("lit_cout", 32'(cout), 32'(xc));
            check("lit_ovf", 32'(ovf), 32'(xo));
            check("lit_zero", 32'(zero), 32'(xz));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    int n_done;

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        sub         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2201, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Abort in the second RUN cycle.
        op_a        = 16'hABCD;
        op_b        = 16'h1111;
        sub         = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_ready", 32'(start_ready), 32'd1);
        check("rst_no_done", 32'(n_done), 32'd0);
        @(posedge clk);
        #1;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);

        // start_valid held high with operands changing every cycle.
        start_valid = 1'b1;
        n_done      = 0;
        repeat (42) begin
            op_a = pick();
            op_b = pick();
            sub  = 1'($urandom);
            @(negedge clk);
            if (done) n_done++;
            @(posedge clk);
            #1;
        end
        start_valid = 1'b0;
        check("held_done_count", 32'(n_done), 32'd7);
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(pick(), pick(), 1'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_addsub16.md
SERIAL_ADDSUB16 -- requirements
Module: serial_addsub16

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start_valid  input  1  operand request present.
REQ-005 start_ready  output  1  block can accept a request.
REQ-006 op_a  input  W  operand A.
REQ-007 op_b  input  W  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 rca_a  output  4  current A nibble to external 4-bit ripple-carry adder.
REQ-010 rca_b  output  4  current B nibble (inverted when subtracting) to adder.
REQ-011 rca_cin  output  1  carry into adder for current nibble.
REQ-012 rca_s  input  4  adder sum nibble (combinational from rca_a/rca_b/rca_cin).
REQ-013 rca_cout  input  1  adder carry out.
REQ-014 result  output  W  registered sum/difference.
REQ-015 cout  output  1  final carry out (sub: 1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  result == 0.
REQ-018 done  output  1  one-cycle pulse, result/flags valid.

Function
REQ-019 FSM states IDLE, RUN, DONE; start_ready SHALL be 1 only in IDLE.
REQ-020 Accept = start_valid && start_ready at a rising edge: latch op_a into a_reg, (sub ? ~op_b : op_b) into b_reg, carry_reg <= sub, idx <= 0, result <= 0, go RUN.
REQ-021 In RUN, rca_a = a_reg[4*idx+3:4*idx], rca_b = b_reg nibble idx, rca_cin = carry_reg (all from registers, no combinational path from start inputs).
REQ-022 Each RUN edge: result nibble idx <= rca_s, carry_reg <= rca_cout, idx <= idx+1; nibbles processed LSB first.
REQ-023 After edge processing idx == NIBBLES-1, go DONE; RUN lasts exactly NIBBLES cycles.
REQ-024 DONE lasts one cycle with done=1, then IDLE; latency accept-edge to done-high = NIBBLES+1 cycles.
REQ-025 cout = carry_reg after final nibble; ovf = (a_reg[W-1] == b_reg[W-1]) && (result[W-1] != a_reg[W-1]); zero = (result == 0); computed from final registered values.
REQ-026 result, cout, ovf, zero SHALL hold from DONE until the next accept; they are not valid during RUN.
REQ-027 In IDLE and DONE, rca_a, rca_b, rca_cin SHALL be 0.
REQ-028 start_valid while in RUN or DONE SHALL be ignored; operand inputs may change freely after accept.
REQ-029 Accept possible in the IDLE cycle immediately following DONE (back-to-back throughput NIBBLES+2 cycles).
REQ-030 Overflow of W-bit arithmetic wraps modulo 2^W; no saturation.

Reset
REQ-031 rst high SHALL immediately force IDLE, idx=0, a_reg=b_reg=0, carry_reg=0, result=0, cout=ovf=zero=0, done=0; start_ready=1 once rst deasserts.
REQ-032 Reset during RUN or DONE SHALL abort the operation with no done pulse; the next accept proceeds normally.

Verification (NIBBLES=4, bench supplies behavioural 4-bit adder on rca_* ports)
REQ-033 add 0x1234 + 0x0FCD -> done 5 cycles after accept, result=0x2201, cout=0, ovf=0, zero=0.
REQ-034 add 0xFFFF + 0x0001 -> result=0x0000, cout=1, zero=1, ovf=0.
REQ-035 sub 0x0005 - 0x0007 -> result=0xFFFE, cout=0, ovf=0; sub 0x8000 - 0x0001 -> result=0x7FFF, ovf=1.
REQ-036 add 0x7FFF + 0x0001 -> result=0x8000, ovf=1, cout=0.
REQ-037 rst pulsed at 2nd RUN cycle -> no done, all outputs 0, start_ready=1; following add 0x0001+0x0001 -> 0x0002.
REQ-038 start_valid held high continuously with changing operands -> accepts only in IDLE, one done per NIBBLES+2 cycles, each result matches operands sampled at its accept.
